// File: rtl/router_pkg.sv
// Shared types and helpers for the 2x2 XY mesh (noc_2x2).
// Optional build macro used by the router: NOC_SYNC_EN.
package router_pkg;

  localparam int PAYLOAD     = 4;
  localparam int X_BITS      = 1;
  localparam int Y_BITS      = 1;
  localparam int X_CNT       = 2;
  localparam int Y_CNT       = 2;
  localparam int PACKET_SIZE = X_BITS + Y_BITS + PAYLOAD;
  localparam int NPORTS      = 3;

  typedef struct packed {
    logic [X_BITS-1:0]  x;
    logic [Y_BITS-1:0]  y;
    logic [PAYLOAD-1:0] payload;
  } packet_t;

  // Port encoding doubles as the round-robin index: LOCAL, XDIR, YDIR.
  typedef enum logic [1:0] {
    LOCAL = 2'd0,
    XDIR  = 2'd1,
    YDIR  = 2'd2
  } port_e;

  // Dimension-ordered routing: resolve x first, then y, then deliver.
  function automatic port_e xy_route(packet_t p, logic [X_BITS-1:0] rx,
                                     logic [Y_BITS-1:0] ry);
    if (p.x != rx) return XDIR;
    else if (p.y != ry) return YDIR;
    else return LOCAL;
  endfunction

  // Cyclic successor over the three port indices.
  function automatic logic [1:0] next_port(logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/router.sv
// One XY mesh router: single-entry input buffers (local, X, Y), route compute,
// per-output round-robin arbiters and the two-phase local PE handshakes.
// NOC_SYNC_EN adds 2-flop synchronisers on req_i and ack_o.
//
// Handshakes:
//  - PE ports are two-phase toggles: a request is pending while req != ack.
//  - Neighbour links use valid/empty: a packet moves on an edge where the
//    sender's x/y_out_valid is high and the receiver's buffer was empty at the
//    start of that cycle (x/y_out_empty). Both sides evaluate the same terms.
module router
  import router_pkg::*;
#(
  parameter int RX = 0,
  parameter int RY = 0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    req_i,
  input  packet_t data_i,
  output logic    ack_i,
  output logic    req_o,
  output packet_t data_o,
  input  logic    ack_o,
  input  logic    x_in_valid,
  input  packet_t x_in_data,
  output logic    x_in_empty,
  output logic    x_out_valid,
  output packet_t x_out_data,
  input  logic    x_out_empty,
  input  logic    y_in_valid,
  input  packet_t y_in_data,
  output logic    y_in_empty,
  output logic    y_out_valid,
  output packet_t y_out_data,
  input  logic    y_out_empty
);

  localparam logic [X_BITS-1:0] MY_X = X_BITS'(RX);
  localparam logic [Y_BITS-1:0] MY_Y = Y_BITS'(RY);

  logic req_s, ack_s;

`ifdef NOC_SYNC_EN
  logic [1:0] req_sync, ack_sync;

  // Two-flop synchronisers ahead of toggle edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync <= {req_sync[0], req_i};
      ack_sync <= {ack_sync[0], ack_o};
    end
  end

  assign req_s = req_sync[1];
  assign ack_s = ack_sync[1];
`else
  assign req_s = req_i;
  assign ack_s = ack_o;
`endif

  packet_t           buf_data [NPORTS];
  logic [NPORTS-1:0] buf_valid;
  logic [1:0]        dest     [NPORTS];
  logic [NPORTS-1:0] want     [NPORTS];
  logic [1:0]        ptr      [NPORTS];
  logic [1:0]        grant    [NPORTS];
  logic [1:0]        scan;
  logic [NPORTS-1:0] found, out_ready, fire, pop;

  // Route compute and per-output round-robin arbitration starting at ptr.
  always_comb begin
    found = '0;
    scan  = 2'd0;
    for (int i = 0; i < NPORTS; i++) dest[i] = xy_route(buf_data[i], MY_X, MY_Y);
    for (int o = 0; o < NPORTS; o++) begin
      want[o]  = '0;
      grant[o] = ptr[o];
      for (int i = 0; i < NPORTS; i++)
        want[o][i] = buf_valid[i] && (dest[i] == 2'(o));
      scan = ptr[o];
      for (int k = 0; k < NPORTS; k++) begin
        if (!found[o] && want[o][scan]) begin
          found[o] = 1'b1;
          grant[o] = scan;
        end
        scan = next_port(scan);
      end
    end
    out_ready[LOCAL] = (req_o == ack_s);
    out_ready[XDIR]  = x_out_empty;
    out_ready[YDIR]  = y_out_empty;
    fire = found & out_ready;
    for (int i = 0; i < NPORTS; i++)
      pop[i] = buf_valid[i] && fire[dest[i]] && (grant[dest[i]] == 2'(i));
  end

  assign x_out_valid = found[XDIR];
  assign x_out_data  = buf_data[grant[XDIR]];
  assign y_out_valid = found[YDIR];
  assign y_out_data  = buf_data[grant[YDIR]];
  assign x_in_empty  = ~buf_valid[XDIR];
  assign y_in_empty  = ~buf_valid[YDIR];

  // Buffer fill/drain, arbiter pointer rotation and PE toggle handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        buf_data[i] <= '0;
        ptr[i]      <= LOCAL;
      end
      ack_i  <= 1'b0;
      req_o  <= 1'b0;
      data_o <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++)
        if (pop[i]) buf_valid[i] <= 1'b0;
      // A buffer only fills when it was empty, so fill never races its drain.
      if ((req_s != ack_i) && !buf_valid[LOCAL]) begin
        buf_valid[LOCAL] <= 1'b1;
        buf_data[LOCAL]  <= data_i;
        ack_i            <= ~ack_i;
      end
      if (x_in_valid && !buf_valid[XDIR]) begin
        buf_valid[XDIR] <= 1'b1;
        buf_data[XDIR]  <= x_in_data;
      end
      if (y_in_valid && !buf_valid[YDIR]) begin
        buf_valid[YDIR] <= 1'b1;
        buf_data[YDIR]  <= y_in_data;
      end
      for (int o = 0; o < NPORTS; o++)
        if (fire[o]) ptr[o] <= next_port(grant[o]);
      if (fire[LOCAL]) begin
        data_o <= buf_data[grant[LOCAL]];
        req_o  <= ~req_o;
      end
    end
  end

endmodule

// File: rtl/noc_2x2.sv
// 2x2 XY mesh top: four routers and their neighbour links.
// Optional build macro (applied inside router): NOC_SYNC_EN.
module noc_2x2
  import router_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i  [X_CNT][Y_CNT],
  input  logic [PACKET_SIZE-1:0] data_i [X_CNT][Y_CNT],
  output logic                   ack_i  [X_CNT][Y_CNT],
  output logic                   req_o  [X_CNT][Y_CNT],
  output logic [PACKET_SIZE-1:0] data_o [X_CNT][Y_CNT],
  input  logic                   ack_o  [X_CNT][Y_CNT]
);

  // Link nets are indexed by the sending router; empties by the receiver.
  logic    xv [X_CNT][Y_CNT];
  packet_t xd [X_CNT][Y_CNT];
  logic    xe [X_CNT][Y_CNT];
  logic    yv [X_CNT][Y_CNT];
  packet_t yd [X_CNT][Y_CNT];
  logic    ye [X_CNT][Y_CNT];

  for (genvar gx = 0; gx < X_CNT; gx++) begin : g_x
    for (genvar gy = 0; gy < Y_CNT; gy++) begin : g_y
      router #(.RX(gx), .RY(gy)) u_router (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i[gx][gy]),
        .data_i     (data_i[gx][gy]),
        .ack_i      (ack_i[gx][gy]),
        .req_o      (req_o[gx][gy]),
        .data_o     (data_o[gx][gy]),
        .ack_o      (ack_o[gx][gy]),
        .x_in_valid (xv[X_CNT-1-gx][gy]),
        .x_in_data  (xd[X_CNT-1-gx][gy]),
        .x_in_empty (xe[gx][gy]),
        .x_out_valid(xv[gx][gy]),
        .x_out_data (xd[gx][gy]),
        .x_out_empty(xe[X_CNT-1-gx][gy]),
        .y_in_valid (yv[gx][Y_CNT-1-gy]),
        .y_in_data  (yd[gx][Y_CNT-1-gy]),
        .y_in_empty (ye[gx][gy]),
        .y_out_valid(yv[gx][gy]),
        .y_out_data (yd[gx][gy]),
        .y_out_empty(ye[gx][Y_CNT-1-gy])
      );
    end
  end

endmodule

// File: tb/tb_noc_2x2.sv
// Self-checking bench for noc_2x2 (default build, NOC_SYNC_EN undefined).
module tb_noc_2x2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_i  [2][2];
  logic [5:0] data_i [2][2];
  logic       ack_i  [2][2];
  logic       req_o  [2][2];
  logic [5:0] data_o [2][2];
  logic       ack_o  [2][2];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Per-destination expected packets; order is enforced per source tag [3:2].
  logic [5:0] exp_q [4][$];
  int         deliv_cnt [4];
  int         deliv_cyc [4];
  logic [5:0] deliv_data [4];
  logic       last_req [4];
  bit         auto_ack [4];
  int         acc_cnt [4];

  noc_2x2 dut (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_i),
    .data_i(data_i),
    .ack_i (ack_i),
    .req_o (req_o),
    .data_o(data_o),
    .ack_o (ack_o)
  );

  // Clock and cycle count (cyc = number of rising edges so far).
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Delivery monitor: scoreboard check, handshake check, PE ack model.
  always @(negedge clk) begin
    for (int x = 0; x < 2; x++) begin
      for (int y = 0; y < 2; y++) begin
        int t;
        int idx;
        t = x * 2 + y;
        if (rst) begin
          last_req[t] = req_o[x][y];
          ack_o[x][y] = 1'b0;
        end else begin
          if (req_o[x][y] !== last_req[t]) begin
            tests_run++;
            if (ack_o[x][y] !== last_req[t]) begin
              tests_failed++;
              $display("FAIL handshake tile %0d: req_o toggled with ack_o=%b, required prior ack %b",
                       t, ack_o[x][y], last_req[t]);
            end
            idx = -1;
            for (int k = 0; k < exp_q[t].size(); k++)
              if (idx < 0 && exp_q[t][k][3:2] == data_o[x][y][3:2]) idx = k;
            tests_run++;
            if (idx < 0) begin
              tests_failed++;
              $display("FAIL scoreboard tile %0d: got unexpected 0x%02h, required none pending", t, data_o[x][y]);
            end else begin
              if (data_o[x][y] !== exp_q[t][idx]) begin
                tests_failed++;
                $display("FAIL scoreboard tile %0d: got 0x%02h, required 0x%02h", t, data_o[x][y], exp_q[t][idx]);
              end
              exp_q[t].delete(idx);
            end
            deliv_cnt[t]++;
            deliv_cyc[t]  = cyc;
            deliv_data[t] = data_o[x][y];
            last_req[t]   = req_o[x][y];
          end
          if (auto_ack[t]) ack_o[x][y] = req_o[x][y];
        end
      end
    end
  end

  // Driver: toggle req_i for one packet and wait (bounded) for ack_i.
  task automatic inject(input int x, input int y, input logic [5:0] pkt,
                        output int t_drive, output int t_acc);
    int d;
    @(negedge clk);
    data_i[x][y] = pkt;
    req_i[x][y]  = ~req_i[x][y];
    d = int'(pkt[5]) * 2 + int'(pkt[4]);
    exp_q[d].push_back(pkt);
    t_drive = cyc;
    t_acc   = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ack_i[x][y] === req_i[x][y]) begin
        t_acc = cyc;
        break;
      end
    end
    tests_run++;
    if (t_acc < 0) begin
      tests_failed++;
      $display("FAIL inject_ack tile %0d: ack_i=%b, required %b within 300 cycles", x * 2 + y, ack_i[x][y], req_i[x][y]);
    end else acc_cnt[x * 2 + y]++;
  endtask

  // Driver: n packets from one PE; dst < 0 picks a random destination each time.
  task automatic send_stream(input int x, input int y, input int dst, input int n, input bit gaps);
    int td, ta, d;
    logic [5:0] pkt;
    for (int s = 0; s < n; s++) begin
      d   = (dst < 0) ? int'($urandom_range(0, 3)) : dst;
      pkt = {2'(d), 2'(x * 2 + y), 2'(s)};
      inject(x, y, pkt, td, ta);
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic wait_deliv(input int t, input int target, input string name);
    int k;
    for (k = 0; k < 300 && deliv_cnt[t] < target; k++) @(negedge clk);
    tests_run++;
    if (deliv_cnt[t] < target) begin
      tests_failed++;
      $display("FAIL %s timeout tile %0d: deliveries=%0d, required %0d", name, t, deliv_cnt[t], target);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    for (int x = 0; x < 2; x++) begin
      for (int y = 0; y < 2; y++) begin
        tests_run += 3;
        if (ack_i[x][y] !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s ack_i[%0d][%0d]: got %b, required 0", name, x, y, ack_i[x][y]);
        end
        if (req_o[x][y] !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s req_o[%0d][%0d]: got %b, required 0", name, x, y, req_o[x][y]);
        end
        if (data_o[x][y] !== 6'h00) begin
          tests_failed++;
          $display("FAIL %s data_o[%0d][%0d]: got 0x%02h, required 0x00", name, x, y, data_o[x][y]);
        end
      end
    end
  endtask

  task automatic check_latency(input string name, input int t, input int exp_cyc, input logic [5:0] exp_data);
    tests_run += 2;
    if (deliv_cyc[t] !== exp_cyc) begin
      tests_failed++;
      $display("FAIL %s latency: req_o toggled at edge %0d, required edge %0d", name, deliv_cyc[t], exp_cyc);
    end
    if (deliv_data[t] !== exp_data) begin
      tests_failed++;
      $display("FAIL %s data: got 0x%02h, required 0x%02h", name, deliv_data[t], exp_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++) begin
        req_i[x][y]  = 1'b0;
        data_i[x][y] = 6'h00;
      end
    for (int t = 0; t < 4; t++) auto_ack[t] = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_one_hop();
    int td, ta, base;
    base = deliv_cnt[1];
    inject(0, 0, 6'b01_0001, td, ta);
    tests_run++;
    if (ta !== td + 1) begin
      tests_failed++;
      $display("FAIL one_hop ack_i: toggled at edge %0d, required edge %0d", ta, td + 1);
    end
    wait_deliv(1, base + 1, "one_hop");
    check_latency("one_hop", 1, ta + 2, 6'h11);
  endtask

  task automatic test_two_hop();
    int td, ta, base;
    base = deliv_cnt[3];
    inject(0, 0, 6'b11_0001, td, ta);
    wait_deliv(3, base + 1, "two_hop");
    check_latency("two_hop", 3, ta + 3, 6'h31);
  endtask

  task automatic test_self();
    int td, ta, base;
    base = deliv_cnt[3];
    inject(1, 1, 6'b11_0100, td, ta);
    wait_deliv(3, base + 1, "self");
    check_latency("self", 3, ta + 1, 6'h34);
  endtask

  task automatic test_contention();
    int base;
    base = deliv_cnt[0];
    fork
      send_stream(0, 1, 0, 2, 1'b0);
      send_stream(1, 0, 0, 2, 1'b0);
      send_stream(1, 1, 0, 2, 1'b0);
    join
    wait_deliv(0, base + 6, "contention");
    repeat (10) @(negedge clk);
    tests_run += 2;
    if (deliv_cnt[0] - base !== 6) begin
      tests_failed++;
      $display("FAIL contention count: got %0d deliveries, required 6", deliv_cnt[0] - base);
    end
    if (exp_q[0].size() !== 0) begin
      tests_failed++;
      $display("FAIL contention pending: got %0d undelivered, required 0", exp_q[0].size());
    end
  endtask

  task automatic test_backpressure();
    int base, a0;
    base = deliv_cnt[0];
    a0   = acc_cnt[1];
    auto_ack[0] = 1'b0;
    fork
      send_stream(0, 1, 0, 6, 1'b0);
      begin
        repeat (50) @(negedge clk);
        tests_run += 2;
        if (deliv_cnt[0] - base !== 1) begin
          tests_failed++;
          $display("FAIL backpressure deliveries: got %0d, required 1", deliv_cnt[0] - base);
        end
        // One packet held in data_o, one in (0,0) Y buffer, one in (0,1) local.
        if (acc_cnt[1] - a0 !== 3) begin
          tests_failed++;
          $display("FAIL backpressure accepted: got %0d, required 3", acc_cnt[1] - a0);
        end
        auto_ack[0] = 1'b1;
      end
    join
    wait_deliv(0, base + 6, "backpressure");
    tests_run++;
    if (exp_q[0].size() !== 0) begin
      tests_failed++;
      $display("FAIL backpressure pending: got %0d undelivered, required 0", exp_q[0].size());
    end
  endtask

  task automatic test_random();
    fork
      send_stream(0, 0, -1, 4, 1'b1);
      send_stream(0, 1, -1, 4, 1'b1);
      send_stream(1, 0, -1, 4, 1'b1);
      send_stream(1, 1, -1, 4, 1'b1);
    join
    repeat (40) @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      tests_run++;
      if (exp_q[t].size() !== 0) begin
        tests_failed++;
        $display("FAIL random pending tile %0d: got %0d undelivered, required 0", t, exp_q[t].size());
      end
    end
  endtask

  task automatic test_reset_mid();
    int td, ta, base;
    inject(0, 0, 6'b11_0010, td, ta);
    @(negedge clk);
    rst = 1'b1;
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++) req_i[x][y] = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_mid");
    for (int t = 0; t < 4; t++) exp_q[t].delete();
    @(negedge clk);
    rst = 1'b0;
    base = deliv_cnt[3];
    repeat (10) @(negedge clk);
    tests_run++;
    if (deliv_cnt[3] !== base) begin
      tests_failed++;
      $display("FAIL reset_mid flush: got %0d deliveries after reset, required 0", deliv_cnt[3] - base);
    end
    base = deliv_cnt[1];
    inject(1, 0, 6'b01_1001, td, ta);
    tests_run++;
    if (ta !== td + 1) begin
      tests_failed++;
      $display("FAIL reset_mid ack_i: toggled at edge %0d, required edge %0d", ta, td + 1);
    end
    wait_deliv(1, base + 1, "reset_mid");
    check_latency("reset_mid", 1, ta + 3, 6'h19);
  endtask

  initial begin
    for (int t = 0; t < 4; t++) begin
      deliv_cnt[t] = 0;
      deliv_cyc[t] = 0;
      acc_cnt[t]   = 0;
      last_req[t]  = 1'b0;
    end
    test_reset();
    test_one_hop();
    test_two_hop();
    test_self();
    test_contention();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
